decode: RTL and testbench
=========================

Name: decode

Overview:
- Combinational MIPS-32 instruction decoder for the pipelined CPU.
- Takes one 32-bit instruction word and produces two things:
  - the ALU operation select used by the execute-stage ALU;
  - the multiply/divide unit operation select and its start strobe.
- Instantiated locally wherever a stage needs control from its own instruction copy (ALU, MD unit).

Parameters:
- None. Encodings are shared package constants.

Ports:
- clk    input   1   clock; interface uniformity only, no state uses it
- reset  input   1   synchronous, active-high; no internal state, so no effect on outputs
- instr  input   32  instruction word (opcode [31:26], funct [5:0])
- ALUOp  output  4   ALU operation select
- MDOp   output  4   multiply/divide operation select
- start  output  1   high for mult, multu, div, divu

Behaviour:
- Purely combinational. Outputs depend only on instr, are valid in the same cycle, and have no latency or registers. Reset value is n/a: outputs track instr even while reset is high.
- ALUOp encoding (4 bits):
  - ADD=0, SUB=1, OR=2, SLL=3, SRL=4, SRA=5, SLLV=6
  - SRLV=7, SRAV=8, AND=9, XOR=10, NOR=11, SLT=12, SLTU=13
  - NONE=15 (the ALU outputs 32'hFFFFFFFF for NONE)
- R-type (opcode 000000), decoded by funct:
  - 100000 add, 100001 addu -> ADD
  - 100010 sub, 100011 subu -> SUB
  - 100100 and -> AND; 100101 or -> OR; 100110 xor -> XOR; 100111 nor -> NOR
  - 101010 slt -> SLT; 101011 sltu -> SLTU
  - 000000 sll -> SLL; 000010 srl -> SRL; 000011 sra -> SRA
  - 000100 sllv -> SLLV; 000110 srlv -> SRLV; 000111 srav -> SRAV
  - Shift-by-immediate ops take the shift amount from instr[10:6] inside the ALU; the decoder only selects the op.
  - All other funct values -> NONE.
- I-type:
  - addi 001000, addiu 001001 -> ADD
  - andi 001100 -> AND; ori 001101 -> OR; xori 001110 -> XOR
  - lui 001111 -> OR (the ALU ORs the pre-shifted immediate with 0)
  - slti 001010 -> SLT; sltiu 001011 -> SLTU
  - Loads and stores (lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011) -> ADD (address calculation)
  - beq 000100, bne 000101 -> SUB
  - Everything else (j, jal, jr, unknown) -> NONE.
- MDOp encoding:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4
  - MTHI=5, MTLO=6, MFHI=7, MFLO=8
- MDOp decode (R-type funct only; any non-R-type opcode -> NONE):
  - 011000 -> MULT; 011001 -> MULTU; 011010 -> DIV; 011011 -> DIVU
  - 010001 -> MTHI; 010011 -> MTLO; 010000 -> MFHI; 010010 -> MFLO
  - Any other funct -> NONE.
- start = 1 iff MDOp is MULT, MULTU, DIV or DIVU; otherwise 0. mthi/mtlo/mfhi/mflo never assert start.
- Boundaries:
  - instr=0 (nop) decodes as sll -> ALUOp=SLL, MDOp=NONE, start=0.
  - X/Z bits on instr are not specified; the default branch yields NONE.
  - The funct field is ignored whenever opcode≠000000.

Decomposition:
- Shared package (decode_pkg): opcode and funct localparams, ALUOp codes, MDOp codes.
- The package is used by the ALU and MD modules as well.
- No sub-module. A single always_comb block holds two case statements (opcode, then funct).

Test Plan:
- add $3,$1,$2 (0x00221820) -> ALUOp=0, MDOp=0, start=0; subu (funct 100011) -> ALUOp=1.
- sra $3,$2,4 (0x00021903) -> ALUOp=5; srav (funct 000111) -> ALUOp=8; nop 0x00000000 -> ALUOp=3.
- ori (0x34220005) -> ALUOp=2; lui (0x3C011234) -> ALUOp=2; lw (0x8C220004) -> ALUOp=0; beq (0x10220003) -> ALUOp=1; j (0x08000000) -> ALUOp=15.
- mult (0x00220018) -> MDOp=1, start=1; divu (0x0022001B) -> MDOp=4, start=1.
- mthi (0x00200011) -> MDOp=5, start=0; mflo (0x00001812) -> MDOp=8, start=0.
- Hold reset=1 and toggle clk while instr=mult -> outputs unchanged (MDOp=1, start=1). Then sweep all 64 funct codes with opcode≠0 -> MDOp=0, start=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared MIPS-32 opcode/funct fields and the ALU / multiply-divide operation codes.
// Imported by the decoder, the ALU and the MD unit.
package decode_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpLh    = 6'b100001;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpLbu   = 6'b100100;
    localparam logic [5:0] OpLhu   = 6'b100101;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpSh    = 6'b101001;
    localparam logic [5:0] OpSw    = 6'b101011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FnSll   = 6'b000000;
    localparam logic [5:0] FnSrl   = 6'b000010;
    localparam logic [5:0] FnSra   = 6'b000011;
    localparam logic [5:0] FnSllv  = 6'b000100;
    localparam logic [5:0] FnSrlv  = 6'b000110;
    localparam logic [5:0] FnSrav  = 6'b000111;
    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnXor   = 6'b100110;
    localparam logic [5:0] FnNor   = 6'b100111;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnSltu  = 6'b101011;

    // ALU operation select
    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluOr   = 4'd2;
    localparam logic [3:0] AluSll  = 4'd3;
    localparam logic [3:0] AluSrl  = 4'd4;
    localparam logic [3:0] AluSra  = 4'd5;
    localparam logic [3:0] AluSllv = 4'd6;
    localparam logic [3:0] AluSrlv = 4'd7;
    localparam logic [3:0] AluSrav = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;
    localparam logic [3:0] AluXor  = 4'd10;
    localparam logic [3:0] AluNor  = 4'd11;
    localparam logic [3:0] AluSlt  = 4'd12;
    localparam logic [3:0] AluSltu = 4'd13;
    localparam logic [3:0] AluNone = 4'd15;

    // Multiply/divide unit operation select
    localparam logic [3:0] MdNone  = 4'd0;
    localparam logic [3:0] MdMult  = 4'd1;
    localparam logic [3:0] MdMultu = 4'd2;
    localparam logic [3:0] MdDiv   = 4'd3;
    localparam logic [3:0] MdDivu  = 4'd4;
    localparam logic [3:0] MdMthi  = 4'd5;
    localparam logic [3:0] MdMtlo  = 4'd6;
    localparam logic [3:0] MdMfhi  = 4'd7;
    localparam logic [3:0] MdMflo  = 4'd8;

    // Only the long-latency arithmetic ops kick off the MD unit; HI/LO moves do not.
    function automatic logic md_starts(input logic [3:0] md_op);
        return (md_op == MdMult) || (md_op == MdMultu) ||
               (md_op == MdDiv)  || (md_op == MdDivu);
    endfunction

endpackage

// File: rtl/decode.sv
// Combinational MIPS-32 decoder: ALU op select plus MD unit op select and start strobe.
// clk/reset exist only for interface uniformity with the other pipeline blocks.
module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [3:0]  ALUOp,
    output logic [3:0]  MDOp,
    output logic        start
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [3:0] alu_op;
    logic [3:0] md_op;
    logic       unused_ctrl;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_ctrl = clk ^ reset;

    always_comb begin
        alu_op = AluNone;
        md_op  = MdNone;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAdd, FnAddu: alu_op = AluAdd;
                    FnSub, FnSubu: alu_op = AluSub;
                    FnAnd:         alu_op = AluAnd;
                    FnOr:          alu_op = AluOr;
                    FnXor:         alu_op = AluXor;
                    FnNor:         alu_op = AluNor;
                    FnSlt:         alu_op = AluSlt;
                    FnSltu:        alu_op = AluSltu;
                    FnSll:         alu_op = AluSll;
                    FnSrl:         alu_op = AluSrl;
                    FnSra:         alu_op = AluSra;
                    FnSllv:        alu_op = AluSllv;
                    FnSrlv:        alu_op = AluSrlv;
                    FnSrav:        alu_op = AluSrav;
                    default:       alu_op = AluNone;
                endcase
                case (funct)
                    FnMult:  md_op = MdMult;
                    FnMultu: md_op = MdMultu;
                    FnDiv:   md_op = MdDiv;
                    FnDivu:  md_op = MdDivu;
                    FnMthi:  md_op = MdMthi;
                    FnMtlo:  md_op = MdMtlo;
                    FnMfhi:  md_op = MdMfhi;
                    FnMflo:  md_op = MdMflo;
                    default: md_op = MdNone;
                endcase
            end
            OpAddi, OpAddiu:         alu_op = AluAdd;
            OpAndi:                  alu_op = AluAnd;
            OpOri:                   alu_op = AluOr;
            OpXori:                  alu_op = AluXor;
            // lui: immediate arrives pre-shifted, ALU ORs it with zero
            OpLui:                   alu_op = AluOr;
            OpSlti:                  alu_op = AluSlt;
            OpSltiu:                 alu_op = AluSltu;
            OpLb, OpLh, OpLw, OpLbu, OpLhu,
            OpSb, OpSh, OpSw:        alu_op = AluAdd;
            OpBeq, OpBne:            alu_op = AluSub;
            default:                 alu_op = AluNone;
        endcase
    end

    assign ALUOp = alu_op;
    assign MDOp  = md_op;
    assign start = md_starts(md_op);

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed vector table, reset/clock hold, funct sweep
// with non-R opcodes, and random instructions against a table-lookup reference model.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  ALUOp;
    logic [3:0]  MDOp;
    logic        start;

    decode dut (
        .clk   (clk),
        .reset (reset),
        .instr (instr),
        .ALUOp (ALUOp),
        .MDOp  (MDOp),
        .start (start)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference lookup tables indexed by funct (R-type) or opcode (others)
    int alu_r_tbl [64];
    int alu_i_tbl [64];
    int md_r_tbl  [64];

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [3:0]  alu;
        logic [3:0]  md;
        logic        st;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: instr=%08h got %0d expected %0d", nm, instr, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ins, output logic [3:0] a,
                                  output logic [3:0] m, output logic s);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (op == 0) begin
            a = 4'(alu_r_tbl[fn]);
            m = 4'(md_r_tbl[fn]);
        end else begin
            a = 4'(alu_i_tbl[op]);
            m = 4'd0;
        end
        s = (m >= 4'd1) && (m <= 4'd4);
    endfunction

    task automatic apply_and_check(input string nm, input logic [31:0] ins);
        logic [3:0] ea, em;
        logic       es;
        @(negedge clk);
        instr = ins;
        #1;
        model(ins, ea, em, es);
        chk({nm, ".ALUOp"}, 32'(ALUOp), 32'(ea));
        chk({nm, ".MDOp"},  32'(MDOp),  32'(em));
        chk({nm, ".start"}, 32'(start), 32'(es));
    endtask

    vec_t vecs [15];

    initial begin
        for (int i = 0; i < 64; i++) begin
            alu_r_tbl[i] = 15;
            alu_i_tbl[i] = 15;
            md_r_tbl[i]  = 0;
        end
        // R-type ALU ops by funct value
        alu_r_tbl[32] = 0;  alu_r_tbl[33] = 0;  alu_r_tbl[34] = 1;  alu_r_tbl[35] = 1;
        alu_r_tbl[36] = 9;  alu_r_tbl[37] = 2;  alu_r_tbl[38] = 10; alu_r_tbl[39] = 11;
        alu_r_tbl[42] = 12; alu_r_tbl[43] = 13; alu_r_tbl[0]  = 3;  alu_r_tbl[2]  = 4;
        alu_r_tbl[3]  = 5;  alu_r_tbl[4]  = 6;  alu_r_tbl[6]  = 7;  alu_r_tbl[7]  = 8;
        // I-type / load-store / branch ALU ops by opcode value
        alu_i_tbl[8]  = 0;  alu_i_tbl[9]  = 0;  alu_i_tbl[12] = 9;  alu_i_tbl[13] = 2;
        alu_i_tbl[14] = 10; alu_i_tbl[15] = 2;  alu_i_tbl[10] = 12; alu_i_tbl[11] = 13;
        alu_i_tbl[32] = 0;  alu_i_tbl[33] = 0;  alu_i_tbl[35] = 0;  alu_i_tbl[36] = 0;
        alu_i_tbl[37] = 0;  alu_i_tbl[40] = 0;  alu_i_tbl[41] = 0;  alu_i_tbl[43] = 0;
        alu_i_tbl[4]  = 1;  alu_i_tbl[5]  = 1;
        // MD ops by funct value
        md_r_tbl[24] = 1; md_r_tbl[25] = 2; md_r_tbl[26] = 3; md_r_tbl[27] = 4;
        md_r_tbl[17] = 5; md_r_tbl[19] = 6; md_r_tbl[16] = 7; md_r_tbl[18] = 8;

        vecs[0]  = '{"add",  32'h00221820, 4'd0,  4'd0, 1'b0};
        vecs[1]  = '{"subu", 32'h00221823, 4'd1,  4'd0, 1'b0};
        vecs[2]  = '{"sra",  32'h00021903, 4'd5,  4'd0, 1'b0};
        vecs[3]  = '{"srav", 32'h00221807, 4'd8,  4'd0, 1'b0};
        vecs[4]  = '{"nop",  32'h00000000, 4'd3,  4'd0, 1'b0};
        vecs[5]  = '{"ori",  32'h34220005, 4'd2,  4'd0, 1'b0};
        vecs[6]  = '{"lui",  32'h3C011234, 4'd2,  4'd0, 1'b0};
        vecs[7]  = '{"lw",   32'h8C220004, 4'd0,  4'd0, 1'b0};
        vecs[8]  = '{"beq",  32'h10220003, 4'd1,  4'd0, 1'b0};
        vecs[9]  = '{"j",    32'h08000000, 4'd15, 4'd0, 1'b0};
        vecs[10] = '{"mult", 32'h00220018, 4'd15, 4'd1, 1'b1};
        vecs[11] = '{"divu", 32'h0022001B, 4'd15, 4'd4, 1'b1};
        vecs[12] = '{"mthi", 32'h00200011, 4'd15, 4'd5, 1'b0};
        vecs[13] = '{"mflo", 32'h00001812, 4'd15, 4'd8, 1'b0};
        vecs[14] = '{"jr",   32'h00200008, 4'd15, 4'd0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            instr = vecs[i].ins;
            #1;
            chk({vecs[i].name, ".ALUOp"}, 32'(ALUOp), 32'(vecs[i].alu));
            chk({vecs[i].name, ".MDOp"},  32'(MDOp),  32'(vecs[i].md));
            chk({vecs[i].name, ".start"}, 32'(start), 32'(vecs[i].st));
        end

        // Reset held high across several edges must not disturb the decode of mult
        @(negedge clk);
        reset = 1'b1;
        instr = 32'h00220018;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("rst_mult.MDOp",  32'(MDOp),  32'd1);
            chk("rst_mult.start", 32'(start), 32'd1);
            chk("rst_mult.ALUOp", 32'(ALUOp), 32'd15);
        end
        @(negedge clk);
        instr = 32'h00221820;
        #1;
        chk("rst_add.ALUOp", 32'(ALUOp), 32'd0);
        reset = 1'b0;

        // Every funct with a non-R opcode: MD unit must stay idle
        for (int f = 0; f < 64; f++) begin
            logic [5:0] op;
            logic [3:0] ea, em;
            logic       es;
            op = 6'($urandom_range(1, 63));
            @(negedge clk);
            instr = {op, 20'($urandom), 6'(f)};
            #1;
            model(instr, ea, em, es);
            chk("sweep.MDOp",  32'(MDOp),  32'd0);
            chk("sweep.start", 32'(start), 32'd0);
            chk("sweep.ALUOp", 32'(ALUOp), 32'(ea));
        end

        // Random instructions, half forced to R-type
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[0]) r[31:26] = 6'd0;
            apply_and_check("rand", r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
